// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the modulo up/down counter family.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   clog2()              : ceiling log2, used to size the prescaler phase counter
//   params_legal()       : range check on WIDTH/MODULUS/PRESCALE, evaluated at
//                          elaboration by the top level
// ----------------------------------------------------------------------------
package counter_pkg;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   function automatic int clog2(input longint value);
      int     bits;
      longint span;
      bits = 0;
      span = 1;
      while (span < value) begin
         span = span * 2;
         bits = bits + 1;
      end
      return bits;
   endfunction

   // MODULUS must fit 2..2**WIDTH; PRESCALE must be at least 1.
   function automatic bit params_legal(input int width, input int modulus,
                                       input int prescale);
      return (modulus >= 2) &&
             (longint'(modulus) <= (longint'(1) << width)) &&
             (prescale >= 1);
   endfunction

endpackage

// File: rtl/count_prescaler.sv
// ----------------------------------------------------------------------------
// count_prescaler
// Divides the count enable by PRESCALE: step is high on every PRESCALE-th
// enabled clock. With PRESCALE=1 the phase counter is stuck at 0 and
// step reduces to en.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   en   : advance the phase
//   clr  : synchronous phase clear (has priority over en)
//   step : combinational, high on the enabled clock that completes a period
// ----------------------------------------------------------------------------
module count_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam int              PHASE_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PRESCALE - 1);
   localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

   logic [PHASE_W-1:0] phase_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_reg <= '0;
      end else if (clr) begin
         phase_reg <= '0;
      end else if (en) begin
         phase_reg <= (phase_reg == LAST_PHASE) ? '0 : phase_reg + PHASE_ONE;
      end
   end

   assign step = en && (phase_reg == LAST_PHASE);

endmodule

// File: rtl/mod_updown_counter.sv
// ----------------------------------------------------------------------------
// mod_updown_counter
// Modulo-MODULUS up/down counter with load, enable, prescaler, wrap or
// saturate at the range ends, terminal-count pulse and sticky overflow.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   en       : count enable (through the prescaler)
//   up       : 1 = increment, 0 = decrement
//   load     : synchronous load, beats en; clears the prescaler phase
//   load_val : value to load, clamped to MODULUS-1
//   clr_ovf  : clears ovf; a simultaneous boundary step wins
//   result   : current count (registered)
//   tc       : one-clock pulse on every boundary step (registered)
//   ovf      : sticky boundary flag (registered)
// ----------------------------------------------------------------------------
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int PRESCALE = 1,
   parameter bit SATURATE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] result,
   output logic             tc,
   output logic             ovf
);

   if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_param_error
      $error("mod_updown_counter: MODULUS must be 2..2**WIDTH and PRESCALE >= 1");
   end

   // With MODULUS = 2**WIDTH this is all-ones, so no extra bit is needed.
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] result_reg, result_next;
   logic             tc_reg, tc_next;
   logic             ovf_reg, ovf_next;
   logic             step;
   logic             boundary;

   count_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .step (step)
   );

   always_comb begin
      result_next = result_reg;
      boundary    = 1'b0;
      if (load) begin
         result_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (step) begin
         if (up) begin
            if (result_reg == MAX_VAL) begin
               boundary    = 1'b1;
               result_next = (SATURATE == MODE_SAT) ? MAX_VAL : '0;
            end else begin
               result_next = result_reg + ONE;
            end
         end else begin
            if (result_reg == '0) begin
               boundary    = 1'b1;
               result_next = (SATURATE == MODE_SAT) ? '0 : MAX_VAL;
            end else begin
               result_next = result_reg - ONE;
            end
         end
      end
      // tc only ever follows a boundary step, so load and idle clocks drop it.
      tc_next  = boundary;
      ovf_next = boundary ? 1'b1 : (clr_ovf ? 1'b0 : ovf_reg);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_reg <= '0;
         tc_reg     <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         result_reg <= result_next;
         tc_reg     <= tc_next;
         ovf_reg    <= ovf_next;
      end
   end

   assign result = result_reg;
   assign tc     = tc_reg;
   assign ovf    = ovf_reg;

endmodule

// File: tb/tb_mod_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_mod_updown_counter
// Four counter instances share one set of inputs:
//   0: default (W=4, M=10, P=1, wrap)   1: saturate (W=4, M=10, P=1)
//   2: prescaled (W=4, M=10, P=3)       3: full range (W=3, M=8, P=2)
// A behavioural model tracks each instance as integers.
// ----------------------------------------------------------------------------
module tb_mod_updown_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, up = 1'b0, load = 1'b0, clr_ovf = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [2:0] load_val3;

   logic [3:0] res0, res1, res2;
   logic [2:0] res3;
   logic       tc0, tc1, tc2, tc3;
   logic       ovf0, ovf1, ovf2, ovf3;

   logic [3:0] d_res [4];
   logic       d_tc  [4];
   logic       d_ovf [4];

   int total = 0;
   int bad   = 0;

   int p_mod [4] = '{10, 10, 10, 8};
   int p_ps  [4] = '{1, 1, 3, 2};
   int p_sat [4] = '{0, 1, 0, 0};
   int m_res [4];
   int m_ph  [4];
   bit m_tc  [4];
   bit m_ovf [4];

   always #5 clk = ~clk;

   assign load_val3 = load_val[2:0];
   assign d_res[0] = res0;  assign d_tc[0] = tc0;  assign d_ovf[0] = ovf0;
   assign d_res[1] = res1;  assign d_tc[1] = tc1;  assign d_ovf[1] = ovf1;
   assign d_res[2] = res2;  assign d_tc[2] = tc2;  assign d_ovf[2] = ovf2;
   assign d_res[3] = {1'b0, res3};  assign d_tc[3] = tc3;  assign d_ovf[3] = ovf3;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1'b0)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr_ovf(clr_ovf), .result(res0), .tc(tc0), .ovf(ovf0));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr_ovf(clr_ovf), .result(res1), .tc(tc1), .ovf(ovf1));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1'b0)) dut_ps (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr_ovf(clr_ovf), .result(res2), .tc(tc2), .ovf(ovf2));

   mod_updown_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(2), .SATURATE(1'b0)) dut_full (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val3),
      .clr_ovf(clr_ovf), .result(res3), .tc(tc3), .ovf(ovf3));

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_res[i] = 0; m_ph[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 4; i++) begin
         int lim;
         int lv;
         bit hit;
         lim = p_mod[i] - 1;
         lv  = (i == 3) ? int'(load_val3) : int'(load_val);
         hit = 1'b0;
         if (!rst) begin
            m_res[i] = 0; m_ph[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
         end else begin
            if (load) begin
               m_res[i] = (lv > lim) ? lim : lv;
               m_ph[i]  = 0;
            end else if (en) begin
               m_ph[i] = m_ph[i] + 1;
               if (m_ph[i] == p_ps[i]) begin
                  m_ph[i] = 0;
                  if (up) begin
                     if (m_res[i] == lim) begin
                        hit = 1'b1;
                        if (p_sat[i] == 0) m_res[i] = 0;
                     end else m_res[i] = m_res[i] + 1;
                  end else begin
                     if (m_res[i] == 0) begin
                        hit = 1'b1;
                        if (p_sat[i] == 0) m_res[i] = lim;
                     end else m_res[i] = m_res[i] - 1;
                  end
               end
            end
            m_tc[i] = hit;
            if (hit) m_ovf[i] = 1'b1;
            else if (clr_ovf) m_ovf[i] = 1'b0;
         end
      end
   endtask

   // One rising edge: advance the model with the inputs sampled there, then
   // move 1 time unit past the edge so outputs have settled.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      rst = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (d_res[i] !== 4'd0 || d_tc[i] !== 1'b0 || d_ovf[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset_state inst%0d got res=%0d tc=%0b ovf=%0b need 0/0/0",
                     i, d_res[i], d_tc[i], d_ovf[i]);
         end
      end
      rst = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         total++;
         if (res0 !== 4'(seq[k]) || tc0 !== (k == 9) || ovf0 !== (k >= 9)) begin
            bad++;
            $display("FAIL reset_count clk%0d got res=%0d tc=%0b ovf=%0b need res=%0d tc=%0b ovf=%0b",
                     k + 1, res0, tc0, ovf0, seq[k], (k == 9), (k >= 9));
         end
      end
   endtask

   task automatic test_load_down();
      int seq [5] = '{2, 1, 0, 9, 8};
      load = 1'b1; load_val = 4'd3; en = 1'b1; up = 1'b1;
      tick();
      total++;
      if (res0 !== 4'd3 || tc0 !== 1'b0) begin
         bad++;
         $display("FAIL load3 got res=%0d tc=%0b need res=3 tc=0", res0, tc0);
      end
      load = 1'b0; up = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (res0 !== 4'(seq[k]) || tc0 !== (k == 3)) begin
            bad++;
            $display("FAIL count_down step%0d got res=%0d tc=%0b need res=%0d tc=%0b",
                     k, res0, tc0, seq[k], (k == 3));
         end
      end
      load = 1'b1; load_val = 4'd15; en = 1'b0;
      tick();
      total++;
      if (res0 !== 4'd9 || res3 !== 3'd7) begin
         bad++;
         $display("FAIL load_clamp got res0=%0d res3=%0d need res0=9 res3=7", res0, res3);
      end
      load = 1'b0;
   endtask

   task automatic test_saturate();
      load = 1'b1; load_val = 4'd8; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if (res1 !== 4'd9 || tc1 !== (k >= 1) || (k >= 1 && ovf1 !== 1'b1)) begin
            bad++;
            $display("FAIL sat_up step%0d got res=%0d tc=%0b ovf=%0b need res=9 tc=%0b",
                     k, res1, tc1, ovf1, (k >= 1));
         end
      end
      en = 1'b0; clr_ovf = 1'b1;
      tick();
      total++;
      if (ovf1 !== 1'b0 || tc1 !== 1'b0) begin
         bad++;
         $display("FAIL sat_clr_ovf got ovf=%0b tc=%0b need ovf=0 tc=0", ovf1, tc1);
      end
      clr_ovf = 1'b0; load = 1'b1; load_val = 4'd0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if (res1 !== 4'd0 || tc1 !== 1'b1 || ovf1 !== 1'b1) begin
            bad++;
            $display("FAIL sat_down step%0d got res=%0d tc=%0b ovf=%0b need 0/1/1",
                     k, res1, tc1, ovf1);
         end
      end
   endtask

   task automatic test_prescale();
      int en_pat  [5] = '{1, 0, 0, 1, 1};
      int res_pat [5] = '{0, 0, 0, 0, 1};
      load = 1'b1; load_val = 4'd0; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         total++;
         if (res2 !== 4'(k / 3) || tc2 !== 1'b0) begin
            bad++;
            $display("FAIL prescale clk%0d got res=%0d tc=%0b need res=%0d tc=0",
                     k, res2, tc2, k / 3);
         end
      end
      load = 1'b1; load_val = 4'd0;
      tick();
      load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         en = en_pat[k][0];
         tick();
         total++;
         if (res2 !== 4'(res_pat[k])) begin
            bad++;
            $display("FAIL prescale_gap clk%0d got res=%0d need %0d", k, res2, res_pat[k]);
         end
      end
   endtask

   task automatic test_simultaneous();
      load = 1'b1; load_val = 4'd0; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      load = 1'b1; load_val = 4'd5;
      tick();
      total++;
      if (res0 !== 4'd5 || res2 !== 4'd5) begin
         bad++;
         $display("FAIL load_beats_en got res0=%0d res2=%0d need 5/5", res0, res2);
      end
      load = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         total++;
         if (res2 !== ((k == 3) ? 4'd6 : 4'd5)) begin
            bad++;
            $display("FAIL load_clears_prescale clk%0d got res=%0d need %0d",
                     k, res2, (k == 3) ? 6 : 5);
         end
      end
      en = 1'b0; clr_ovf = 1'b1;
      tick();
      total++;
      if (ovf0 !== 1'b0) begin
         bad++;
         $display("FAIL clr_ovf got ovf=%0b need 0", ovf0);
      end
      clr_ovf = 1'b0; load = 1'b1; load_val = 4'd9;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1; clr_ovf = 1'b1;
      tick();
      total++;
      if (res0 !== 4'd0 || tc0 !== 1'b1 || ovf0 !== 1'b1) begin
         bad++;
         $display("FAIL set_beats_clr got res=%0d tc=%0b ovf=%0b need 0/1/1", res0, tc0, ovf0);
      end
      clr_ovf = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         load     = ($urandom_range(0, 9) == 0);
         en       = ($urandom_range(0, 9) < 7);
         up       = $urandom_range(0, 1) == 1;
         clr_ovf  = ($urandom_range(0, 9) == 0);
         load_val = 4'($urandom_range(0, 15));
         tick();
         for (int i = 0; i < 4; i++) begin
            total++;
            if (d_res[i] !== 4'(m_res[i]) || d_tc[i] !== m_tc[i] || d_ovf[i] !== m_ovf[i]) begin
               bad++;
               $display("FAIL random cyc%0d inst%0d got res=%0d tc=%0b ovf=%0b need res=%0d tc=%0b ovf=%0b",
                        k, i, d_res[i], d_tc[i], d_ovf[i], m_res[i], m_tc[i], m_ovf[i]);
            end
         end
      end
      load = 1'b0; clr_ovf = 1'b0;
   endtask

   task automatic test_async_reset();
      bit seen;
      seen = 1'b0;
      load = 1'b1; load_val = 4'd0; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick();
         if (tc0 === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL async_reset_wait got no tc within 40 clocks need tc=1");
      end else begin
         #3 rst = 1'b0;
         #1;
         model_reset();
         for (int i = 0; i < 4; i++) begin
            total++;
            if (d_res[i] !== 4'd0 || d_tc[i] !== 1'b0 || d_ovf[i] !== 1'b0) begin
               bad++;
               $display("FAIL async_reset inst%0d got res=%0d tc=%0b ovf=%0b need 0/0/0",
                        i, d_res[i], d_tc[i], d_ovf[i]);
            end
         end
         tick();
         rst = 1'b1;
         tick();
         total++;
         if (res0 !== 4'd1 || tc0 !== 1'b0 || ovf0 !== 1'b0 || res2 !== 4'(m_res[2])) begin
            bad++;
            $display("FAIL after_release got res0=%0d tc=%0b ovf=%0b res2=%0d need 1/0/0 res2=%0d",
                     res0, tc0, ovf0, res2, m_res[2]);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_down();
      test_saturate();
      test_prescale();
      test_simultaneous();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
